// File: rtl/mbist_controller.sv
// mbist_controller: March-style memory BIST sequencer and checker.
//
// For each background pattern q = 0..NUM_PATTERNS-1 the controller writes the
// whole array with the decoder output data_t, reads it back, and compares each
// returned word against the pattern that was registered when the read was issued.
//
// Ports:
//   clk, rst      clock (rising edge), asynchronous active-high reset
//   start         begin a run; honoured only in IDLE or DONE
//   q             pattern select driven to the external decoder
//   data_t        decoder output; also the memory write data
//   addr, we, re  memory address, write enable, read enable (1-cycle read latency)
//   rdata         memory read data
//   busy, done    run in progress / run finished (held until the next start)
//   fail          sticky mismatch flag for the current run
//   fail_count    mismatch count, saturating at 255
//   fail_addr     address of the first mismatch
//   fail_q        pattern select of the first mismatch
module mbist_controller #(
  parameter int ADDR_WIDTH   = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int NUM_PATTERNS = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [2:0]            q,
  input  logic [DATA_WIDTH-1:0] data_t,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  we,
  output logic                  re,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [7:0]            fail_count,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [2:0]            fail_q
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;
  localparam logic [2:0]            Q_LAST    = 3'(NUM_PATTERNS - 1);

  state_t                  state;
  state_t                  state_nxt;
  logic [2:0]              q_nxt;
  logic [ADDR_WIDTH-1:0]   addr_nxt;
  logic                    clear_log;

  logic                    vld_p1;
  logic [ADDR_WIDTH-1:0]   addr_p1;
  logic [2:0]              q_p1;
  logic [DATA_WIDTH-1:0]   exp_p1;
  logic                    mismatch_p1;

  function automatic logic [7:0] sat_inc(input logic [7:0] cnt);
    return (cnt == 8'hFF) ? cnt : cnt + 8'd1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      q     <= '0;
      addr  <= '0;
    end else begin
      state <= state_nxt;
      q     <= q_nxt;
      addr  <= addr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    q_nxt     = q;
    addr_nxt  = addr;
    clear_log = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = WRITE;
          q_nxt     = '0;
          addr_nxt  = '0;
          clear_log = 1'b1;
        end
      end
      WRITE: begin
        addr_nxt = addr + ADDR_WIDTH'(1);
        if (addr == ADDR_LAST) begin
          state_nxt = READ;
          addr_nxt  = '0;
        end
      end
      READ: begin
        addr_nxt = addr + ADDR_WIDTH'(1);
        if (addr == ADDR_LAST) begin
          state_nxt = DRAIN;
          addr_nxt  = '0;
        end
      end
      DRAIN: begin
        // The final read of this pattern is being checked this cycle.
        addr_nxt = '0;
        if (q == Q_LAST) begin
          state_nxt = DONE;
        end else begin
          state_nxt = WRITE;
          q_nxt     = q + 3'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign we   = (state == WRITE);
  assign re   = (state == READ);
  assign busy = (state == WRITE) || (state == READ) || (state == DRAIN);
  assign done = (state == DONE);

  // Stage p1: read issued last cycle; rdata now valid, compare against pattern
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= re;
    end
  end

  always_ff @(posedge clk) begin
    addr_p1 <= addr;
    q_p1    <= q;
    exp_p1  <= data_t;
  end

  // 4-state compare so that X/Z read data is flagged as a mismatch.
  assign mismatch_p1 = vld_p1 && (rdata !== exp_p1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fail       <= 1'b0;
      fail_count <= '0;
      fail_addr  <= '0;
      fail_q     <= '0;
    end else if (clear_log) begin
      fail       <= 1'b0;
      fail_count <= '0;
      fail_addr  <= '0;
      fail_q     <= '0;
    end else if (mismatch_p1) begin
      fail       <= 1'b1;
      fail_count <= sat_inc(fail_count);
      if (!fail) begin
        fail_addr <= addr_p1;
        fail_q    <= q_p1;
      end
    end
  end

endmodule

// File: tb/tb_mbist_controller.sv
// tb_mbist_controller: scoreboard bench for mbist_controller.
// A pattern decoder and a 1-cycle-latency RAM with injectable faults surround
// the DUT. Each run's expected result is queued before its start pulse; a
// negedge monitor checks the per-cycle q/addr/we/re sequence of every run and
// pops/compares the queued result whenever done rises.
module tb_mbist_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] q;
  logic [7:0] data_t;
  logic [3:0] addr;
  logic       we;
  logic       re;
  logic [7:0] rdata;
  logic       busy;
  logic       done;
  logic       fail;
  logic [7:0] fail_count;
  logic [3:0] fail_addr;
  logic [2:0] fail_q;

  mbist_controller #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .NUM_PATTERNS(6)) dut (
    .clk(clk), .rst(rst), .start(start), .q(q), .data_t(data_t),
    .addr(addr), .we(we), .re(re), .rdata(rdata), .busy(busy), .done(done),
    .fail(fail), .fail_count(fail_count), .fail_addr(fail_addr), .fail_q(fail_q)
  );

  always #5 clk = ~clk;

  // Pattern decoder: bit0 set in patterns 1,3,5; only pattern 5 is all-ones.
  always_comb begin
    data_t = 'x;
    case (q)
      3'd0: data_t = 8'h00;
      3'd1: data_t = 8'h55;
      3'd2: data_t = 8'hAA;
      3'd3: data_t = 8'h33;
      3'd4: data_t = 8'hCC;
      3'd5: data_t = 8'hFF;
      default: data_t = 'x;
    endcase
  end

  // Memory model with read-side fault injection.
  logic [7:0] mem [16];
  logic       sa0_en = 1'b0;
  logic [3:0] sa0_addr = 4'd0;
  logic       sa1_en = 1'b0;
  logic [3:0] sa1_addr = 4'd0;

  function automatic logic [7:0] faulty(input logic [7:0] d, input logic [3:0] a);
    logic [7:0] r;
    r = d;
    if (sa0_en && a == sa0_addr) r[0] = 1'b0;
    if (sa1_en && a == sa1_addr) r = 8'hFF;
    return r;
  endfunction

  always @(posedge clk) begin
    if (we) mem[addr] <= data_t;
    if (re) rdata <= faulty(mem[addr], addr);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total  = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  typedef struct {
    logic       fail;
    logic [7:0] cnt;
    logic [3:0] faddr;
    logic [2:0] fq;
  } exp_t;

  exp_t sb[$];

  function automatic exp_t mk(input logic f, input logic [7:0] c, input logic [3:0] a, input logic [2:0] fq);
    exp_t e;
    e.fail = f; e.cnt = c; e.faddr = a; e.fq = fq;
    return e;
  endfunction

  // Monitor: sequence tracking and scoreboard pop on done.
  logic busy_q = 1'b0;
  logic done_q = 1'b0;
  int   run_start = 0;
  logic seq_bad = 1'b0;

  always @(negedge clk) begin
    int k, r, p;
    exp_t e;
    if (busy && !busy_q) begin
      run_start = cyc;
      seq_bad   = 1'b0;
    end
    if (busy) begin
      k = cyc - run_start;
      r = k % 33;
      p = k / 33;
      if (we !== (r < 16) || re !== (r >= 16 && r < 32) || q !== 3'(p)) seq_bad = 1'b1;
      if (r < 32 && addr !== 4'(r % 16)) seq_bad = 1'b1;
    end
    if (done && !done_q) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("run_cycles", 32'(cyc - run_start), 32'd198);
        check("run_sequence", {31'd0, seq_bad}, 32'd0);
        check("fail", {31'd0, fail}, {31'd0, e.fail});
        check("fail_count", {24'd0, fail_count}, {24'd0, e.cnt});
        check("fail_addr", {28'd0, fail_addr}, {28'd0, e.faddr});
        check("fail_q", {29'd0, fail_q}, {29'd0, e.fq});
      end
    end
    busy_q = busy;
    done_q = done;
  end

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done) return;
    end
    total++;
    $display("FAIL %s: got no done within 400 cycles, expected done", name);
  endtask

  task automatic check_all_zero(input string name);
    check(name, {q, addr, we, re, busy, done, fail, fail_count, fail_addr, fail_q}, 32'd0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset_outputs");
    rst = 1'b0;
    @(negedge clk);
    check("idle_done", {31'd0, done}, 32'd0);

    // 1: fault-free run
    sb.push_back(mk(1'b0, 8'd0, 4'd0, 3'd0));
    pulse_start();
    wait_done("t1_done");
    repeat (3) @(negedge clk);
    check("done_held", {30'd0, done, busy}, 32'd2);

    // 2: bit0 stuck-at-0 at addr 5
    sa0_en = 1'b1; sa0_addr = 4'd5;
    sb.push_back(mk(1'b1, 8'd3, 4'd5, 3'd1));
    pulse_start();
    wait_done("t2_done");

    // 3: all bits stuck-at-1 at addr 15
    sa0_en = 1'b0;
    sa1_en = 1'b1; sa1_addr = 4'd15;
    sb.push_back(mk(1'b1, 8'd5, 4'd15, 3'd0));
    pulse_start();
    wait_done("t3_done");

    // 6: restart from failing DONE with fault removed
    sa1_en = 1'b0;
    @(negedge clk);
    check("fail_held_in_done", {31'd0, fail}, 32'd1);
    sb.push_back(mk(1'b0, 8'd0, 4'd0, 3'd0));
    pulse_start();
    check("log_cleared", {fail, fail_count, fail_addr, fail_q}, 32'd0);
    check("busy_after_restart", {31'd0, busy}, 32'd1);
    wait_done("t6_done");

    // 5: start pulse mid-run is ignored
    sb.push_back(mk(1'b0, 8'd0, 4'd0, 3'd0));
    pulse_start();
    repeat (9) @(negedge clk);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_done("t5_done");

    // 4: async reset mid-run, then clean run
    pulse_start();
    repeat (40) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_all_zero("async_reset_outputs");
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    check_all_zero("post_reset_idle");
    sb.push_back(mk(1'b0, 8'd0, 4'd0, 3'd0));
    pulse_start();
    wait_done("t4_done");

    // 8: start held high through DONE restarts the run
    sb.push_back(mk(1'b0, 8'd0, 4'd0, 3'd0));
    sb.push_back(mk(1'b0, 8'd0, 4'd0, 3'd0));
    @(negedge clk) start = 1'b1;
    @(negedge clk);
    wait_done("t8_done_a");
    @(negedge clk);
    check("restart_from_done", {31'd0, busy}, 32'd1);
    wait_done("t8_done_b");
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("stay_done", {31'd0, done}, 32'd1);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
